// File: rtl/scanner_comm_rx.sv
// scanner_comm_rx: receive side of the 2-bit inter-scanner command link
// Captures one-cycle command pulses from a peer scanner, queues them in a DEPTH-entry FIFO
// and replays each to the local scanner, holding it for HOLD_CYCLES cycles.
// Ports: clk, reset (sync, active-high), comm_in[1:0], flush -> comm_out[1:0], busy,
//        fifo_count[clog2(DEPTH):0], overflow (sticky), drop_count[3:0] (saturating),
//        code_hex[6:0] (active-low 7-seg, only when COMM_RX_HEX_EN is defined)
module scanner_comm_rx #(
  parameter int ID          = 0,
  parameter int DEPTH       = 4,
  parameter int HOLD_CYCLES = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [1:0]                 comm_in,
  input  logic                       flush,
  output logic [1:0]                 comm_out,
  output logic                       busy,
  output logic [$clog2(DEPTH):0]     fifo_count,
  output logic                       overflow,
  output logic [3:0]                 drop_count
`ifdef COMM_RX_HEX_EN
  ,
  output logic [6:0]                 code_hex
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic [1:0] {IDLE, PRESENT, GAP} state_t;
  state_t state_q, state_d;
  logic [1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [1:0] prev_q, comm_q, comm_d;
  logic [3:0] hold_q, hold_d, drop_q, drop_d;
  logic ovf_q, ovf_d;
  logic push, pop, full, wr_en, drop;
  always_comb begin
    push = comm_in != 2'b00 && comm_in != prev_q;
    pop = state_q == IDLE && count_q != '0;
    full = count_q == CW'(DEPTH);
    wr_en = push && (!full || pop) && !flush;
    drop = push && full && !pop && !flush;
    wr_ptr_d = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d = count_q + CW'(wr_en) - CW'(pop);
    ovf_d = ovf_q | drop;
    drop_d = drop && drop_q != 4'd15 ? drop_q + 4'd1 : drop_q;
    state_d = state_q;
    comm_d = comm_q;
    hold_d = hold_q;
    case (state_q)
      IDLE: if (pop) begin
        comm_d = mem_q[rd_ptr_q];
        hold_d = 4'd1;
        state_d = PRESENT;
      end
      PRESENT: if (hold_q == 4'(HOLD_CYCLES)) begin
        comm_d = 2'b00;
        state_d = GAP;
      end else hold_d = hold_q + 4'd1;
      default: state_d = IDLE;
    endcase
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d = '0;
      ovf_d = 1'b0;
      drop_d = 4'd0;
      state_d = IDLE;
      comm_d = 2'b00;
      hold_d = 4'd0;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
      prev_q <= 2'b00;
      comm_q <= 2'b00;
      hold_q <= 4'd0;
      drop_q <= 4'd0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
      prev_q <= comm_in;
      comm_q <= comm_d;
      hold_q <= hold_d;
      drop_q <= drop_d;
      ovf_q <= ovf_d;
    end
  end
  always_ff @(posedge clk) if (!reset && wr_en) mem_q[wr_ptr_q] <= comm_in;
  assign comm_out = comm_q;
  assign busy = state_q != IDLE || count_q != '0;
  assign fifo_count = count_q;
  assign overflow = ovf_q;
  assign drop_count = drop_q;
`ifdef COMM_RX_HEX_EN
  always_comb code_hex = comm_q == 2'b00 ? 7'b1111110 :
                         comm_q == 2'b01 ? 7'b0100100 :
                         comm_q == 2'b10 ? 7'b0110001 : 7'b0111000;
`endif
endmodule

// File: tb/tb_scanner_comm_rx.sv
// tb_scanner_comm_rx: randomized + directed check of scanner_comm_rx against a queue/countdown model
module tb_scanner_comm_rx;
  localparam int DEPTH = 4;
  localparam int HOLD = 3;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic flush = 1'b0;
  logic [1:0] comm_in = 2'b00;
  logic [1:0] comm_out;
  logic busy;
  logic [$clog2(DEPTH):0] fifo_count;
  logic overflow;
  logic [3:0] drop_count;
`ifdef COMM_RX_HEX_EN
  logic [6:0] code_hex;
`endif
  always #5 clk = ~clk;
  scanner_comm_rx #(.ID(0), .DEPTH(DEPTH), .HOLD_CYCLES(HOLD)) dut (
    .clk(clk),
    .reset(reset),
    .comm_in(comm_in),
    .flush(flush),
    .comm_out(comm_out),
    .busy(busy),
    .fifo_count(fifo_count),
    .overflow(overflow),
    .drop_count(drop_count)
`ifdef COMM_RX_HEX_EN
    ,
    .code_hex(code_hex)
`endif
  );
  int n_chk = 0;
  int n_pass = 0;
  int q[$];
  int t = 0;
  int cur = 0;
  int prev = 0;
  int ovf = 0;
  int drops = 0;
  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
  endtask
  function automatic int hex_of(input int c);
    return c == 0 ? 7'b1111110 : c == 1 ? 7'b0100100 : c == 2 ? 7'b0110001 : 7'b0111000;
  endfunction
  task automatic cycle(input logic r, input logic f, input logic [1:0] c);
    logic pop, push;
    int exp_out;
    reset = r;
    flush = f;
    comm_in = c;
    @(posedge clk);
    if (r) begin
      q.delete();
      t = 0; cur = 0; prev = 0; ovf = 0; drops = 0;
    end else begin
      pop = t == 0 && q.size() > 0;
      push = c != 0 && int'(c) != prev;
      if (f) begin
        q.delete();
        t = 0; ovf = 0; drops = 0;
      end else begin
        if (pop) begin
          cur = q.pop_front();
          t = HOLD + 1;
        end else if (t > 0) t--;
        if (push) begin
          if (q.size() < DEPTH) q.push_back(int'(c));
          else begin
            ovf = 1;
            if (drops < 15) drops++;
          end
        end
      end
      prev = int'(c);
    end
    #1;
    exp_out = t >= 2 ? cur : 0;
    chk("comm_out", int'(comm_out), exp_out);
    chk("busy", int'(busy), int'(t > 0 || q.size() > 0));
    chk("fifo_count", int'(fifo_count), q.size());
    chk("overflow", int'(overflow), ovf);
    chk("drop_count", int'(drop_count), drops);
`ifdef COMM_RX_HEX_EN
    chk("code_hex", int'(code_hex), hex_of(exp_out));
`endif
  endtask
  initial begin
    logic [1:0] c;
    int k;
    repeat (2) cycle(1, 0, 0);
    repeat (3) cycle(0, 0, 0);
    cycle(0, 0, 2);
    repeat (10) cycle(0, 0, 0);
    repeat (4) cycle(0, 0, 1);
    repeat (12) cycle(0, 0, 0);
    cycle(0, 0, 1); cycle(0, 0, 2); cycle(0, 0, 3);
    repeat (20) cycle(0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      cycle(0, 0, 2'((i % 3) + 1));
      cycle(0, 0, 0);
    end
    repeat (40) cycle(0, 0, 0);
    cycle(0, 0, 1); cycle(0, 0, 2); cycle(0, 0, 3); cycle(0, 0, 0);
    cycle(0, 1, 3);
    repeat (10) cycle(0, 0, 0);
    cycle(0, 0, 2); cycle(0, 0, 0); cycle(0, 0, 0);
    cycle(1, 0, 0);
    repeat (5) cycle(0, 0, 0);
    c = 2'b00;
    for (int i = 0; i < 3000; i++) begin
      k = $urandom_range(0, 9);
      c = k < 5 ? c : k < 8 ? 2'b00 : 2'($urandom_range(0, 3));
      cycle($urandom_range(0, 199) == 0, $urandom_range(0, 99) == 0, c);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
